// File: rtl/kbd_mmio.sv
// kbd_mmio: memory-mapped PS/2 keyboard responder (read-only CPU port).
//
// Receives PS/2 device-to-host frames and validates start, odd parity and
// stop. Good scancodes are buffered in a FIFO. CPU reads are answered with
// a one-cycle stall handshake.
//
// Ports:
//   clk       ui_clk, all logic on posedge
//   rst       synchronous active-high reset
//   ps2_clk   asynchronous PS/2 clock from keyboard
//   ps2_data  asynchronous PS/2 data from keyboard
//   rd_en     address-qualified CPU read strobe, held high while stalled
//   rd_addr   word select: 0 = DATA, 1 = STATUS
//   rd_data   registered read result
//   rd_stall  combinational stall, rd_en & ~rd_done
//   kbd_irq   registered, high while the FIFO is non-empty
//
// Optional feature macro: KBD_BREAK_FILTER_EN. When it is defined, a break
// prefix (8'hF0) and the byte that follows it are not queued, so the FIFO
// holds make codes only.
module kbd_mmio #(
    parameter int FIFO_AW     = 4,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rd_en,
    input  logic        rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_stall,
    output logic        kbd_irq
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // A frame is good when the 8 data bits plus the parity bit hold an odd
    // number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{p, b};
    endfunction

    logic [1:0]         clk_sync_r, data_sync_r;
    logic [FW-1:0]      filt_cnt_r;
    logic               filt_clk_r, filt_prev_r;
    logic               fall_s, ps2_d_s;
    rx_state_t          state_r, state_nxt_s;
    logic [7:0]         shift_r;
    logic [2:0]         bit_cnt_r;
    logic               par_r;
    logic [TW-1:0]      to_cnt_r;
    logic               timeout_s, frame_ok_s, frame_bad_s, push_s, perr_set_s;
    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic               full_s, nonempty_s, pop_s, wr_en_s, ovf_set_s;
    logic               ovf_r, perr_r, rd_done_r, access_s, stat_rd_s;
    logic [31:0]        rd_data_r;
    logic               kbd_irq_r;

    assign ps2_d_s = data_sync_r[1];
    // The delayed copy makes the falling edge a one-cycle pulse.
    assign fall_s  = filt_prev_r & ~filt_clk_r;

    // Two-flop synchronisers for the asynchronous PS/2 lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    // Glitch filter: the output follows the input only after FILTER_LEN
    // consecutive samples that differ from the current output.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt_r  <= '0;
            filt_clk_r  <= 1'b1;
            filt_prev_r <= 1'b1;
        end else begin
            filt_prev_r <= filt_clk_r;
            if (clk_sync_r[1] == filt_clk_r) begin
                filt_cnt_r <= '0;
            end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
                filt_cnt_r <= '0;
                filt_clk_r <= clk_sync_r[1];
            end else begin
                filt_cnt_r <= filt_cnt_r + FW'(1);
            end
        end
    end

    // A timeout aborts a partial frame. A falling edge in the same cycle
    // takes priority, because that edge reloads the counter.
    assign timeout_s = (state_r != ST_IDLE) && !fall_s && (to_cnt_r == TW'(TIMEOUT_CYC));

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Receiver next-state logic. The FSM advances only on falling edges.
    always_comb begin
        state_nxt_s = state_r;
        if (timeout_s) begin
            state_nxt_s = ST_IDLE;
        end else if (fall_s) begin
            case (state_r)
                ST_IDLE:   state_nxt_s = ps2_d_s ? ST_IDLE : ST_DATA;
                ST_DATA:   state_nxt_s = (bit_cnt_r == 3'd7) ? ST_PARITY : ST_DATA;
                ST_PARITY: state_nxt_s = ST_STOP;
                ST_STOP:   state_nxt_s = ST_IDLE;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

`ifdef KBD_BREAK_FILTER_EN
    logic skip_r;

    // Skip flag: armed by a good F0 and cleared by the next good byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_r <= 1'b0;
        end else if (frame_ok_s) begin
            skip_r <= skip_r ? 1'b0 : (shift_r == 8'hF0);
        end else begin
            skip_r <= skip_r;
        end
    end
`endif

    // Receiver outputs: frame verdict at the stop bit and the FIFO push.
    always_comb begin
        frame_ok_s  = 1'b0;
        frame_bad_s = 1'b0;
        if (fall_s && (state_r == ST_STOP)) begin
            if (ps2_d_s && odd_parity_ok(shift_r, par_r)) begin
                frame_ok_s = 1'b1;
            end else begin
                frame_bad_s = 1'b1;
            end
        end else begin
            frame_ok_s  = 1'b0;
            frame_bad_s = 1'b0;
        end
`ifdef KBD_BREAK_FILTER_EN
        push_s = frame_ok_s && !skip_r && (shift_r != 8'hF0);
`else
        push_s = frame_ok_s;
`endif
        perr_set_s = frame_bad_s | timeout_s;
    end

    // Receiver datapath: LSB-first shift register, bit count, parity and
    // the timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
            par_r     <= 1'b0;
            to_cnt_r  <= '0;
        end else begin
            if (fall_s || (state_r == ST_IDLE) || timeout_s) begin
                to_cnt_r <= '0;
            end else begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end
            if (fall_s) begin
                case (state_r)
                    ST_IDLE:   bit_cnt_r <= 3'd0;
                    ST_DATA: begin
                        shift_r   <= {ps2_d_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end
                    ST_PARITY: par_r <= ps2_d_s;
                    default:   bit_cnt_r <= bit_cnt_r;
                endcase
            end
        end
    end

    assign full_s     = (count_r == CW'(DEPTH));
    assign nonempty_s = (count_r != '0);
    assign access_s   = rd_en & ~rd_done_r;
    assign stat_rd_s  = access_s & rd_addr;
    assign pop_s      = access_s & ~rd_addr & nonempty_s;
    // A pop in the same cycle frees a slot, so a push is accepted even
    // when the FIFO is full.
    assign wr_en_s    = push_s & (~full_s | pop_s);
    assign ovf_set_s  = push_s & full_s & ~pop_s;

    // FIFO storage. It is not reset, because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
            if (pop_s)   rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags. A STATUS read clears them, but a set event in the
    // same cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r  <= 1'b0;
            perr_r <= 1'b0;
        end else begin
            ovf_r  <= ovf_set_s  | (ovf_r  & ~stat_rd_s);
            perr_r <= perr_set_s | (perr_r & ~stat_rd_s);
        end
    end

    // Read handshake: capture the word once per access and raise the
    // interrupt while data is queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_done_r <= 1'b0;
            rd_data_r <= 32'h0000_0000;
            kbd_irq_r <= 1'b0;
        end else begin
            rd_done_r <= rd_en;
            kbd_irq_r <= nonempty_s;
            if (access_s) begin
                if (rd_addr) begin
                    rd_data_r <= {28'd0, ovf_r, perr_r, full_s, nonempty_s};
                end else begin
                    rd_data_r <= {23'd0, nonempty_s, nonempty_s ? mem_r[rd_ptr_r] : 8'h00};
                end
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_stall = access_s;
    assign kbd_irq  = kbd_irq_r;
endmodule

// File: tb/tb_kbd_mmio.sv
module tb_kbd_mmio;
    localparam int TO_CYC = 3000;

    logic        clk = 1'b0;
    logic        rst, ps2_clk, ps2_data, rd_en, rd_addr;
    logic [31:0] rd_data;
    logic        rd_stall, kbd_irq;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    kbd_mmio #(.FIFO_AW(4), .FILTER_LEN(8), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_stall(rd_stall), .kbd_irq(kbd_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device-to-host frame: start 0, 8 data bits LSB-first, odd parity, stop 1.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            wait_cyc(10);
            ps2_clk = 1'b0;
            wait_cyc(20);
            ps2_clk = 1'b1;
            wait_cyc(10);
        end
        ps2_data = 1'b1;
        wait_cyc(30);
    endtask

    // One CPU read: the stall lasts one cycle, then the data is compared
    // against the head of the scoreboard.
    task automatic do_read(input logic addr, input string tag);
        logic [31:0] e;
        @(negedge clk);
        rd_addr = addr;
        rd_en   = 1'b1;
        #1;
        chk({tag, "_stall_hi"}, {31'd0, rd_stall}, 32'd1);
        @(negedge clk);
        chk({tag, "_stall_lo"}, {31'd0, rd_stall}, 32'd0);
        vectors++;
        assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end
        if (exp_q.size() != 0) begin
            vectors--;
            e = exp_q.pop_front();
            chk({tag, "_data"}, rd_data, e);
        end
        rd_en = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; rd_addr = 1'b0;
        wait_cyc(5);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_stall", {31'd0, rd_stall}, 32'd0);
        chk("rst_irq", {31'd0, kbd_irq}, 32'd0);
        rst = 1'b0;
        wait_cyc(3);

        // Good frame, then two DATA reads.
        send_frame(8'h1C, 1'b0, 11);
        chk("irq_after_frame", {31'd0, kbd_irq}, 32'd1);
        exp_q.push_back(32'h0000_011C);
        do_read(1'b0, "data_1c");
        exp_q.push_back(32'h0000_0000);
        do_read(1'b0, "data_empty");
        chk("irq_after_drain", {31'd0, kbd_irq}, 32'd0);

        // Bad parity: nothing queued, perr reported once.
        send_frame(8'h1C, 1'b1, 11);
        exp_q.push_back(32'h0000_0004);
        do_read(1'b1, "stat_perr");
        exp_q.push_back(32'h0000_0000);
        do_read(1'b1, "stat_clr");

        // Overflow: 17 frames into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 11);
        exp_q.push_back(32'h0000_000B);
        do_read(1'b1, "stat_ovf");
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({23'd0, 1'b1, 8'(i)});
            do_read(1'b0, "data_fill");
        end
        exp_q.push_back(32'h0000_0000);
        do_read(1'b1, "stat_after_fill");

        // Partial frame aborted by the timeout, then a good frame.
        send_frame(8'hFF, 1'b0, 4);
        wait_cyc(TO_CYC + 200);
        send_frame(8'h2A, 1'b0, 11);
        exp_q.push_back(32'h0000_012A);
        do_read(1'b0, "data_2a");
        exp_q.push_back(32'h0000_0004);
        do_read(1'b1, "stat_timeout");

        // Reset mid-frame and during a stalled read.
        send_frame(8'h77, 1'b0, 11);
        send_frame(8'h33, 1'b0, 5);
        @(negedge clk);
        rd_addr = 1'b0; rd_en = 1'b1; rst = 1'b1;
        #1;
        chk("rst_stall_during", {31'd0, rd_stall}, 32'd1);
        @(negedge clk);
        chk("midrst_rd_data", rd_data, 32'h0);
        chk("midrst_irq", {31'd0, kbd_irq}, 32'd0);
        rd_en = 1'b0; rst = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, rd_stall}, 32'd0);
        wait_cyc(3);
        send_frame(8'h55, 1'b0, 11);
        exp_q.push_back(32'h0000_0155);
        do_read(1'b0, "data_55");
        exp_q.push_back(32'h0000_0000);
        do_read(1'b0, "data_after_55");
        exp_q.push_back(32'h0000_0000);
        do_read(1'b1, "stat_after_rst");

        // Break-code sequence.
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        send_frame(8'h32, 1'b0, 11);
`ifdef KBD_BREAK_FILTER_EN
        exp_q.push_back(32'h0000_0132);
        do_read(1'b0, "brk_32");
`else
        exp_q.push_back(32'h0000_01F0);
        do_read(1'b0, "brk_f0");
        exp_q.push_back(32'h0000_011C);
        do_read(1'b0, "brk_1c");
        exp_q.push_back(32'h0000_0132);
        do_read(1'b0, "brk_32");
`endif
        exp_q.push_back(32'h0000_0000);
        do_read(1'b0, "brk_empty");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
